// File: rtl/serializer.sv
// +--------------------------------------------------------------------+
// | serializer: start/MSB-first data/stop framer paced by a shift strobe |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
`default_nettype none

module serializer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data_in,
  input  logic             i_load,
  input  logic             i_shift_en,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_shift_out,
  output logic             o_done
);

  localparam int             C_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            r_state;
  logic [C_CW-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_hold;
  logic              r_shift_out;
  logic              r_done;
  logic              r_busy;
  logic              r_ready;

  state_t            w_state_nxt;
  logic [C_CW-1:0]   w_cnt_nxt;
  logic [WIDTH-1:0]  w_hold_nxt;
  logic              w_shift_out_nxt;
  logic              w_done_nxt;
  logic              w_busy_nxt;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_hold_nxt      = r_hold;
    w_shift_out_nxt = r_shift_out;
    w_done_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_load && r_ready) begin
          w_hold_nxt      = i_data_in;
          w_cnt_nxt       = '0;
          w_state_nxt     = S_START;
          w_shift_out_nxt = 1'b1;
        end
      end
      S_START: begin
        if (i_shift_en) begin
          w_state_nxt     = S_DATA;
          w_shift_out_nxt = r_hold[WIDTH-1];
        end
      end
      S_DATA: begin
        if (i_shift_en) begin
          if (r_cnt == C_LAST) begin
            w_state_nxt     = S_STOP;
            w_shift_out_nxt = 1'b0;
          end else begin
            // Present the bit that becomes the MSB after this shift.
            w_cnt_nxt       = r_cnt + C_CW'(1);
            w_hold_nxt      = {r_hold[WIDTH-2:0], 1'b0};
            w_shift_out_nxt = r_hold[WIDTH-2];
          end
        end
      end
      S_STOP: begin
        if (i_shift_en) begin
          w_state_nxt     = S_IDLE;
          w_shift_out_nxt = 1'b0;
          w_done_nxt      = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_shift_out_nxt = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_shift_out <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold      <= w_hold_nxt;
      r_shift_out <= w_shift_out_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= w_busy_nxt;
      r_ready     <= ~w_busy_nxt;
    end
  end

  assign o_ready     = r_ready;
  assign o_busy      = r_busy;
  assign o_shift_out = r_shift_out;
  assign o_done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_serializer.sv
// +--------------------------------------------------------------------+
// | tb_serializer: frame-level model plus directed frames for serializer |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_serializer;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         load;
  logic         se;
  logic [W-1:0] din;
  logic         ready;
  logic         busy;
  logic         so;
  logic         done;

  int checks = 0;
  int errors = 0;

  serializer #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_data_in  (din),
    .i_load     (load),
    .i_shift_en (se),
    .o_ready    (ready),
    .o_busy     (busy),
    .o_shift_out(so),
    .o_done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  // Frame model: a frame is a list of line bits; one bit leaves per strobe.
  logic m_bits[$];
  logic m_active = 1'b0;
  logic m_done   = 1'b0;
  logic m_so     = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_bits.delete();
      m_active = 1'b0;
      m_done   = 1'b0;
      m_so     = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_active) begin
        if (load) begin
          m_bits.delete();
          m_bits.push_back(1'b1);
          for (int i = W - 1; i >= 0; i--) m_bits.push_back(din[i]);
          m_bits.push_back(1'b0);
          m_so     = m_bits.pop_front();
          m_active = 1'b1;
        end
      end else if (se) begin
        if (m_bits.size() > 0) begin
          m_so = m_bits.pop_front();
        end else begin
          m_active = 1'b0;
          m_done   = 1'b1;
          m_so     = 1'b0;
        end
      end
    end
  end

  // Downstream 4-bit shift register fed by the serial line.
  logic [3:0] q = 4'b0000;
  always @(posedge clk) if (se) q <= {q[2:0], so};

  logic seen[$];
  int   ndone = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("shift_out", {31'b0, so},    {31'b0, m_so});
      chk("busy",      {31'b0, busy},  {31'b0, m_active});
      chk("ready",     {31'b0, ready}, {31'b0, ~m_active});
      chk("done",      {31'b0, done},  {31'b0, m_done});
      if (busy) seen.push_back(so);
      if (done) ndone++;
    end
  end

  function automatic logic [31:0] pack(input int base, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r = {r[30:0], seen[base + i]};
    return r;
  endfunction

  task automatic wait_done(input int prev, input bit toggle);
    int k = 0;
    while (ndone == prev && k < 40) begin
      @(negedge clk);
      if (toggle) se = ~se;
      k++;
    end
    chk("done_seen", {31'b0, (ndone > prev)}, 32'd1);
  endtask

  int base;
  int nd0;

  initial begin
    rst  = 1'b0;
    load = 1'b1;
    din  = 4'b1011;
    se   = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("rst_ready",     {31'b0, ready}, 32'd1);
    chk("rst_busy",      {31'b0, busy},  32'd0);
    chk("rst_shift_out", {31'b0, so},    32'd0);
    chk("rst_done",      {31'b0, done},  32'd0);

    // Frame 1011 with constant strobe; Load held through reset.
    @(negedge clk);
    @(negedge clk);
    base = seen.size();
    nd0  = ndone;
    rst  = 1'b0;
    @(negedge clk);
    chk("first_accept_busy", {31'b0, busy}, 32'd1);
    load = 1'b0;
    din  = 4'b0000;
    repeat (5) @(negedge clk);
    chk("downstream_q", {28'b0, q}, 32'h0000000b);
    chk("stop_bit",     {31'b0, so}, 32'd0);
    wait_done(nd0, 1'b0);
    chk("f1011_len",  seen.size() - base, 32'd6);
    chk("f1011_bits", pack(base, 6), 32'b110110);

    // Frame 0110 loaded in the Done cycle, strobe toggling.
    base = seen.size();
    nd0  = ndone;
    load = 1'b1;
    din  = 4'b0110;
    se   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    se   = 1'b0;
    wait_done(nd0, 1'b1);
    chk("f0110_len",  seen.size() - base, 32'd12);
    chk("f0110_bits", pack(base, 12), 32'b110011110000);
    repeat (3) @(negedge clk);
    chk("f0110_done_once", ndone, nd0 + 1);

    // Frame 1111 with Load held high and DataIn=0000 during the frame.
    se   = 1'b1;
    base = seen.size();
    nd0  = ndone;
    load = 1'b1;
    din  = 4'b1111;
    @(negedge clk);
    din  = 4'b0000;
    wait_done(nd0, 1'b0);
    chk("f1111_len",  seen.size() - base, 32'd6);
    chk("f1111_bits", pack(base, 6), 32'b111110);
    base = seen.size();
    nd0  = ndone;
    @(negedge clk);
    load = 1'b0;
    wait_done(nd0, 1'b0);
    chk("f0000_len",  seen.size() - base, 32'd6);
    chk("f0000_bits", pack(base, 6), 32'b100000);

    // Frame 1010 aborted by reset after its second data bit.
    repeat (2) @(negedge clk);
    nd0  = ndone;
    load = 1'b1;
    din  = 4'b1010;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk("abort_data1", {31'b0, so}, 32'd1);
    @(negedge clk);
    chk("abort_data2", {31'b0, so}, 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_shift_out", {31'b0, so},    32'd0);
    chk("abort_busy",      {31'b0, busy},  32'd0);
    chk("abort_ready",     {31'b0, ready}, 32'd1);
    chk("abort_done",      {31'b0, done},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", ndone, nd0);

    base = seen.size();
    nd0  = ndone;
    load = 1'b1;
    din  = 4'b0001;
    @(negedge clk);
    load = 1'b0;
    wait_done(nd0, 1'b0);
    chk("f0001_len",  seen.size() - base, 32'd6);
    chk("f0001_bits", pack(base, 6), 32'b100010);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, legal range 2..32.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset; forces reset state immediately, independent of Clk.
REQ-004 DataIn  input  WIDTH  parallel word to transmit; sampled only on an accepted load.
REQ-005 Load  input  1  request to transmit DataIn; accepted on a rising edge where Load=1 and Ready=1.
REQ-006 ShiftEn  input  1  bit-pacing strobe; frame advances only on rising edges where ShiftEn=1.
REQ-007 Ready  output  1  high when block can accept a Load.
REQ-008 Busy  output  1  high while a frame is in progress (START, DATA or STOP state).
REQ-009 ShiftOut  output  1  registered serial bit stream; drives the downstream shift register's ShiftIn.
REQ-010 Done  output  1  single-cycle pulse marking frame completion.

Function
REQ-011 FSM states IDLE, START, DATA, STOP; all outputs registered, glitch-free.
REQ-012 IDLE: Ready=1, Busy=0, ShiftOut=0 (line idle level).
REQ-013 Edge with Load=1 and Ready=1: DataIn captured into internal WIDTH-bit holding register, bit counter cleared, state->START, ShiftOut=1 (start bit); ShiftEn is ignored on this edge.
REQ-014 Load with Ready=0 is ignored; holding register and frame unaffected.
REQ-015 Edges with ShiftEn=0 in START/DATA/STOP: state, counter, ShiftOut all hold.
REQ-016 START + ShiftEn edge: state->DATA, ShiftOut=holding[WIDTH-1] (MSB first).
REQ-017 DATA + ShiftEn edge: if counter < WIDTH-1, counter increments, holding register shifts left by one (zero-fill), ShiftOut=new MSB; if counter = WIDTH-1, state->STOP, ShiftOut=0 (stop bit).
REQ-018 STOP + ShiftEn edge: state->IDLE, Done=1 for exactly the following cycle, Ready=1 from that same cycle.
REQ-019 Frame length = WIDTH+2 bit periods (start, WIDTH data, stop); each bit held for one ShiftEn-qualified period.
REQ-020 Done=0 in all other cycles; Done never asserted in a cycle with Busy=1.
REQ-021 Ready = not Busy at all times; earliest new Load accepted on the edge ending the Done cycle (one idle cycle minimum between frames).
REQ-022 Counter width ceil(log2(WIDTH)); no wrap-around permitted within a frame.
REQ-023 DataIn changes after acceptance have no effect on the frame in progress.

Reset
REQ-024 Reset=1: state=IDLE, Ready=1, Busy=0, ShiftOut=0, Done=0, counter=0, holding register=0, asynchronously.
REQ-025 Reset mid-frame aborts the frame; no Done pulse; no partial data retained.
REQ-026 Load asserted while Reset=1 is ignored; first acceptance on first edge after Reset deasserts.

Verification (WIDTH=4 unless stated)
REQ-027 Reset 10 ns, then idle -> ShiftOut=0, Ready=1, Busy=0, Done=0.
REQ-028 Load DataIn=4'b1011, ShiftEn=1 constant -> ShiftOut 1,1,0,1,1,0 on successive cycles, Done one cycle after stop bit, Ready=1 with Done.
REQ-029 Load 4'b0110, ShiftEn toggled 1/0 each cycle -> each bit held two cycles; sequence 1,0,1,1,0,0; Done once.
REQ-030 Load 4'b1111 then Load=1 with DataIn=4'b0000 during frame -> second load ignored, frame bits 1,1,1,1,1,0; new load accepted only after Done.
REQ-031 Reset asserted after second data bit of 4'b1010 -> ShiftOut=0, Busy=0, no Done; subsequent load of 4'b0001 transmits 1,0,0,0,1,0.
REQ-032 Chain ShiftOut to downstream 4-bit shift register ShiftIn, load 4'b1011, ShiftEn=1 -> after 5th bit period register Q=4'b1011.
